// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM state encoding and
// funct3 access-size constants.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // funct3 bit that selects zero-extension for loads
  localparam int UNSIGNED_BIT = 2;

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: byte strobes, write-data replication,
// load formatting and the misaligned/illegal-access flag.
module lsu_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            req_off_i,
  input  logic [2:0]            req_funct3_i,
  input  logic                  req_store_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            rd_off_i,
  input  logic [2:0]            rd_funct3_i,
  input  logic [DATA_WIDTH-1:0] rd_bus_dat_i,
  output logic [3:0]            sel_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  misaligned_o
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  sext;

  always_comb begin
    sel_o        = '0;
    wdata_o      = req_wdata_i;
    misaligned_o = 1'b0;
    case (req_funct3_i[1:0])
      SIZE_B: begin
        sel_o   = 4'b0001 << req_off_i;
        wdata_o = {(DATA_WIDTH/8){req_wdata_i[7:0]}};
      end
      SIZE_H: begin
        sel_o        = 4'b0011 << {req_off_i[1], 1'b0};
        wdata_o      = {(DATA_WIDTH/16){req_wdata_i[15:0]}};
        misaligned_o = req_off_i[0];
      end
      SIZE_W: begin
        sel_o        = 4'b1111;
        misaligned_o = |req_off_i;
      end
      default: misaligned_o = 1'b1;
    endcase
    // there is no unsigned store
    if (req_store_i && req_funct3_i[UNSIGNED_BIT]) misaligned_o = 1'b1;
  end

  always_comb begin
    shifted = rd_bus_dat_i >> {rd_off_i, 3'b000};
    sext    = ~rd_funct3_i[UNSIGNED_BIT];
    case (rd_funct3_i[1:0])
      SIZE_B:  rdata_o = {{(DATA_WIDTH-8){sext & shifted[7]}}, shifted[7:0]};
      SIZE_H:  rdata_o = {{(DATA_WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: stalls the pipeline while a single bus
// transfer is in flight, with a bounded wait for the ack.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [DATA_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [2:0]            i_funct3_M,
  output logic                  o_stall_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_bus_cyc,
  output logic                  o_bus_we,
  output logic [DATA_WIDTH-1:0] o_bus_adr,
  output logic [3:0]            o_bus_sel,
  output logic [DATA_WIDTH-1:0] o_bus_dat,
  input  logic [DATA_WIDTH-1:0] i_bus_dat,
  input  logic                  i_bus_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                state_q, state_d;
  logic                  cyc_q, cyc_d, we_q, we_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  logic [3:0]            sel_q, sel_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stall_c, misaligned_c, req;
  logic [3:0]            al_sel;
  logic [DATA_WIDTH-1:0] al_wdata, al_rdata;
  logic                  al_mis;

  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .req_off_i    (i_addr_M[1:0]),
    .req_funct3_i (i_funct3_M),
    .req_store_i  (i_mem_write_M),
    .req_wdata_i  (i_write_data_M),
    .rd_off_i     (off_q),
    .rd_funct3_i  (funct3_q),
    .rd_bus_dat_i (i_bus_dat),
    .sel_o        (al_sel),
    .wdata_o      (al_wdata),
    .rdata_o      (al_rdata),
    .misaligned_o (al_mis)
  );

  assign req = i_mem_read_M | i_mem_write_M;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    err_d        = 1'b0;
    stall_c      = 1'b0;
    misaligned_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (al_mis) begin
            misaligned_c = 1'b1;
          end else begin
            stall_c  = 1'b1;
            state_d  = ST_BUSY;
            cyc_d    = 1'b1;
            we_d     = i_mem_write_M;
            adr_d    = {i_addr_M[DATA_WIDTH-1:2], 2'b00};
            sel_d    = al_sel;
            dat_d    = al_wdata;
            off_d    = i_addr_M[1:0];
            funct3_d = i_funct3_M;
            cnt_d    = '0;
          end
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        // ack takes priority over a coincident timeout
        if (i_bus_ack) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          if (!we_q) rdata_d = al_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign o_stall_M     = stall_c & rst;
  assign o_misaligned  = misaligned_c & rst;
  assign o_read_data_M = rdata_q;
  assign o_bus_err     = err_q;
  assign o_bus_cyc     = cyc_q;
  assign o_bus_we      = we_q;
  assign o_bus_adr     = adr_q;
  assign o_bus_sel     = sel_q;
  assign o_bus_dat     = dat_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of BUSY cycles allowed without an ack.
REQ-003 SHALL have one clock; reset is asynchronous and active-low. Ports clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 i_mem_read_M  in  1  load present in MEM stage.
REQ-007 i_mem_write_M  in  1  store present in MEM stage.
REQ-008 i_addr_M  in  DATA_WIDTH  byte address.
REQ-009 i_write_data_M  in  DATA_WIDTH  store data, LSB-justified.
REQ-010 i_funct3_M  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-011 o_stall_M  out  1  holds IF/ID/EX/MEM pipeline registers.
REQ-012 o_read_data_M  out  DATA_WIDTH  aligned, extended load result.
REQ-013 o_misaligned  out  1  access rejected (misaligned or illegal size).
REQ-014 o_bus_err  out  1  one-cycle pulse on timeout.
REQ-015 o_bus_cyc, o_bus_we  out  1 each  bus cycle active, write enable.
REQ-016 o_bus_adr  out  DATA_WIDTH  word address, bits [1:0] = 0.
REQ-017 o_bus_sel  out  4  byte-lane strobes.
REQ-018 o_bus_dat  out  DATA_WIDTH  lane-replicated write data.
REQ-019 i_bus_dat  in  DATA_WIDTH  raw read word.
REQ-020 i_bus_ack  in  1  transfer complete, sampled only while o_bus_cyc = 1.

Function
REQ-021 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-022 In IDLE, when a request (read or write) is aligned and legal: o_stall_M = 1 combinationally; address, sel, data and we are registered; next state is BUSY.
REQ-023 If read and write are both high, the access SHALL be a store.
REQ-024 Misaligned or illegal accesses SHALL produce o_misaligned = 1 combinationally in IDLE, o_stall_M = 0, no bus cycle and no state change. Cases: half with addr[0] = 1; word with addr[1:0] != 0; funct3[1:0] = 11; store with funct3[2] = 1.
REQ-025 In BUSY: o_bus_cyc = 1 and o_stall_M = 1. Registered bus outputs SHALL stay stable until ack or timeout.
REQ-026 Ack in BUSY SHALL register the formatted read data (loads) and move to DONE. o_bus_cyc SHALL be 0 in DONE.
REQ-027 In DONE: o_stall_M = 0 and o_read_data_M is valid for exactly this cycle. Requests are ignored. Next state is IDLE.
REQ-028 Minimum latency with ack in the first BUSY cycle: 3 cycles from request, 2 stall cycles.
REQ-029 Sel encoding:
- byte: 1 << addr[1:0]
- half: 0011 << (2*addr[1])
- word: 1111
REQ-030 Write data encoding: byte replicated 4x, half replicated 2x, word unchanged.
REQ-031 Read formatting: shift i_bus_dat right by 8*addr[1:0]; sign-extend from bit 7/15 when funct3[2] = 0, otherwise zero-extend.
REQ-032 A BUSY-cycle counter SHALL increment each BUSY cycle without ack. When the count reaches TIMEOUT_CYCLES-1: drop cyc, pulse o_bus_err, force read data to 0, go to DONE.
REQ-033 Ack in the same cycle as timeout SHALL win: no o_bus_err, real data returned.
REQ-034 An ack while idle SHALL be ignored.

Reset
REQ-035 Reset assertion SHALL immediately force: state IDLE, o_bus_cyc 0, o_bus_we 0, o_bus_sel 0, o_bus_adr 0, o_bus_dat 0, o_read_data_M 0, o_bus_err 0, counter 0. This holds even mid-BUSY.
REQ-036 While rst = 0, o_stall_M = 0 and o_misaligned = 0.
REQ-037 The first request SHALL be accepted on the first clock edge after deassertion.

Structure
REQ-038 The shared package SHALL hold the FSM state encodings and the funct3 size constants (SIZE_B/H/W, UNSIGNED bit index).
REQ-039 The block SHALL contain one combinational sub-module, lsu_align, producing sel, replicated write data, read formatting and the misaligned flag.

Verification
REQ-040 SW 0xDEADBEEF to 0x100, ack on the first BUSY cycle -> adr 0x100, sel 1111, we 1, stall 2 cycles, no error.
REQ-041 LB at 0x203 with bus word 0x80FF_0000 -> sel 1000, o_read_data_M = 0xFFFFFF80. The same access as LBU -> 0x00000080.
REQ-042 LH at 0x101 -> o_misaligned = 1, o_bus_cyc never asserted, o_stall_M = 0.
REQ-043 LW with ack withheld and TIMEOUT_CYCLES = 4 -> cyc drops after 4 BUSY cycles, o_bus_err pulses once, o_read_data_M = 0 in DONE.
REQ-044 Reset asserted in the second BUSY cycle -> o_bus_cyc = 0 asynchronously. After release, a new LW completes normally.
REQ-045 SH 0x1234 to 0x302 -> sel 1100, o_bus_dat = 0x12341234.
